// File: rtl/bz_serializer_if.sv
// ============================================================================
//  Module   : bz_serializer_if
//  Purpose  : Channel bundle carrying 32-bit core words into the serializer.
//             A word transfers on a rising clock edge with v=1 and a=1.
//  Signals  : d[31:0] - core word (bits [31:30] are code bits)
//             v       - word valid, driven by the source
//             a       - accept, driven by the sink
//  Modports : master - word source (drives d, v; samples a)
//             slave  - word sink   (samples d, v; drives a)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bz_serializer_if #(
  parameter int NPCin = 32
);
  logic [NPCin-1:0] d;
  logic             v;
  logic             a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

`default_nettype wire

// File: rtl/bz_serializer.sv
// ============================================================================
//  Module   : bz_serializer
//  Purpose  : Turns each accepted 32-bit core word into a 4-flit router packet
//             (header flit carrying the route, then three 10-bit data flits,
//             tail bit set on the last) and writes the flits into the FIFO
//             that feeds the router. Flit format is {tail, payload[9:0]}.
//  Ports    : clk           - clock
//             reset         - asynchronous, active-high reset
//             PC_in_channel - core word channel (slave side; drives a)
//             route[9:0]    - packet route, captured together with d
//             data_out[10:0]- flit to FIFO
//             wrreq         - FIFO write request (one flit per cycle)
//             isfull        - FIFO full flag
//             code_err      - sticky: an accepted word had d[31:30] != 0
//             busy          - high whenever a packet is in progress
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bz_serializer #(
  parameter int NPCin    = 32,
  parameter int NPCroute = 10
) (
  input  wire logic                clk,
  input  wire logic                reset,
  bz_serializer_if.slave           PC_in_channel,
  input  wire logic [NPCroute-1:0] route,
  output logic      [NPCroute:0]   data_out,
  output logic                     wrreq,
  input  wire logic                isfull,
  output logic                     code_err,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_D0   = 3'd2;
  localparam logic [2:0] S_D1   = 3'd3;
  localparam logic [2:0] S_D2   = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [NPCin-3:0] r_word;   // code bits [31:30] are never routed
  logic [NPCroute-1:0] r_route;
  logic             w_xfer;

  // Accept is combinational, so a transfer happens exactly when the FSM is
  // able to take a word this cycle (IDLE, or D2 with the tail being written).
  assign w_xfer = PC_in_channel.v & PC_in_channel.a;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_xfer)  w_state_nxt = S_HDR;
      S_HDR:  if (!isfull) w_state_nxt = S_D0;
      S_D0:   if (!isfull) w_state_nxt = S_D1;
      S_D1:   if (!isfull) w_state_nxt = S_D2;
      S_D2:   if (!isfull) w_state_nxt = PC_in_channel.v ? S_HDR : S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    data_out        = '0;
    wrreq           = 1'b0;
    PC_in_channel.a = 1'b0;
    case (r_state)
      S_IDLE: PC_in_channel.a = 1'b1;
      S_HDR: begin
        data_out = {1'b0, r_route};
        wrreq    = !isfull;
      end
      S_D0: begin
        data_out = {1'b0, r_word[29:20]};
        wrreq    = !isfull;
      end
      S_D1: begin
        data_out = {1'b0, r_word[19:10]};
        wrreq    = !isfull;
      end
      S_D2: begin
        // Next word is accepted on the same edge the tail is written, which
        // gives back-to-back packets with no idle cycle.
        data_out        = {1'b1, r_word[9:0]};
        wrreq           = !isfull;
        PC_in_channel.a = !isfull;
      end
      default: begin
        data_out        = '0;
        wrreq           = 1'b0;
        PC_in_channel.a = 1'b0;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // ---------------------------------------------------------------- capture
  // Word and route only move on a transfer so flits stay stable for the
  // whole packet regardless of what the source does with d/route.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word   <= '0;
      r_route  <= '0;
      code_err <= 1'b0;
    end else if (w_xfer) begin
      r_word  <= PC_in_channel.d[NPCin-3:0];
      r_route <= route;
      if (PC_in_channel.d[NPCin-1:NPCin-2] != 2'b00) code_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bz_serializer.sv
// ============================================================================
//  Module   : tb_bz_serializer
//  Purpose  : Directed self-checking bench for bz_serializer. Inputs change
//             1 time unit after the rising edge; outputs are checked just
//             before the next rising edge, i.e. the values the FIFO samples.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bz_serializer;

  logic        clk;
  logic        reset;
  logic [9:0]  route;
  logic [10:0] data_out;
  logic        wrreq;
  logic        isfull;
  logic        code_err;
  logic        busy;

  int n_cmp;
  int n_err;
  int n_wr;

  bz_serializer_if ch ();

  bz_serializer dut (
    .clk           (clk),
    .reset         (reset),
    .PC_in_channel (ch),
    .route         (route),
    .data_out      (data_out),
    .wrreq         (wrreq),
    .isfull        (isfull),
    .code_err      (code_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check the pre-edge outputs of the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic exp_wr, input logic [10:0] exp_data,
                     input logic exp_a);
    #3;
    chk({tag, ".wrreq"}, {31'd0, wrreq}, {31'd0, exp_wr});
    chk({tag, ".data"},  {21'd0, data_out}, {21'd0, exp_data});
    chk({tag, ".a"},     {31'd0, ch.a}, {31'd0, exp_a});
    if (wrreq === 1'b1) n_wr++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_wr  = 0;
    reset = 1'b1;
    isfull = 1'b0;
    route = '0;
    ch.d = '0;
    ch.v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst.a",        {31'd0, ch.a},     32'd1);
    chk("rst.wrreq",    {31'd0, wrreq},    32'd0);
    chk("rst.data",     {21'd0, data_out}, 32'd0);
    chk("rst.busy",     {31'd0, busy},     32'd0);
    chk("rst.code_err", {31'd0, code_err}, 32'd0);
    @(posedge clk);
    #1;

    // ---- Single word
    ch.d = 32'h2ABC_DEF5; route = 10'h155; ch.v = 1'b1;
    cyc("s1.idle", 1'b0, 11'h000, 1'b1);
    ch.v = 1'b0; ch.d = 32'h0; route = 10'h0;
    n_wr = 0;
    cyc("s1.hdr", 1'b1, 11'h155, 1'b0);
    cyc("s1.d0",  1'b1, 11'h2AB, 1'b0);
    cyc("s1.d1",  1'b1, 11'h337, 1'b0);
    cyc("s1.d2",  1'b1, 11'h6F5, 1'b1);
    cyc("s1.end", 1'b0, 11'h000, 1'b1);
    chk("s1.nwr", n_wr, 32'd4);
    chk("s1.code_err", {31'd0, code_err}, 32'd0);
    chk("s1.busy",     {31'd0, busy},     32'd0);

    // ---- Backpressure in D1
    ch.d = 32'h2ABC_DEF5; route = 10'h155; ch.v = 1'b1;
    cyc("bp.idle", 1'b0, 11'h000, 1'b1);
    ch.v = 1'b0;
    n_wr = 0;
    cyc("bp.hdr", 1'b1, 11'h155, 1'b0);
    cyc("bp.d0",  1'b1, 11'h2AB, 1'b0);
    isfull = 1'b1;
    cyc("bp.full0", 1'b0, 11'h337, 1'b0);
    cyc("bp.full1", 1'b0, 11'h337, 1'b0);
    cyc("bp.full2", 1'b0, 11'h337, 1'b0);
    isfull = 1'b0;
    cyc("bp.d1",  1'b1, 11'h337, 1'b0);
    cyc("bp.d2",  1'b1, 11'h6F5, 1'b1);
    cyc("bp.end", 1'b0, 11'h000, 1'b1);
    chk("bp.nwr", n_wr, 32'd4);

    // ---- Back-to-back, plus a full stall in D2 with v held high
    ch.d = 32'h0000_0001; route = 10'h001; ch.v = 1'b1;
    cyc("bb.idle", 1'b0, 11'h000, 1'b1);
    ch.d = 32'h3FFF_FFFF; route = 10'h3FF;
    cyc("bb.hdr0", 1'b1, 11'h001, 1'b0);
    cyc("bb.d00",  1'b1, 11'h000, 1'b0);
    cyc("bb.d10",  1'b1, 11'h000, 1'b0);
    isfull = 1'b1;
    cyc("bb.d2full", 1'b0, 11'h401, 1'b0);
    isfull = 1'b0;
    cyc("bb.d20",  1'b1, 11'h401, 1'b1);
    ch.v = 1'b0;
    cyc("bb.hdr1", 1'b1, 11'h3FF, 1'b0);
    cyc("bb.d01",  1'b1, 11'h3FF, 1'b0);
    cyc("bb.d11",  1'b1, 11'h3FF, 1'b0);
    cyc("bb.d21",  1'b1, 11'h7FF, 1'b1);
    cyc("bb.end",  1'b0, 11'h000, 1'b1);
    chk("bb.code_err", {31'd0, code_err}, 32'd0);

    // ---- Code error
    ch.d = 32'hC000_0000; route = 10'h000; ch.v = 1'b1;
    cyc("ce.idle", 1'b0, 11'h000, 1'b1);
    ch.v = 1'b0; ch.d = 32'h0;
    chk("ce.code_err", {31'd0, code_err}, 32'd1);
    cyc("ce.hdr", 1'b1, 11'h000, 1'b0);
    cyc("ce.d0",  1'b1, 11'h000, 1'b0);
    cyc("ce.d1",  1'b1, 11'h000, 1'b0);
    cyc("ce.d2",  1'b1, 11'h400, 1'b1);

    // ---- Input stability: d/route scrambled every cycle after transfer
    ch.d = 32'h1234_5678; route = 10'h0A5; ch.v = 1'b1;
    cyc("st.idle", 1'b0, 11'h000, 1'b1);
    ch.v = 1'b0;
    ch.d = $urandom; route = 10'($urandom);
    cyc("st.hdr", 1'b1, 11'h0A5, 1'b0);
    ch.d = $urandom; route = 10'($urandom);
    cyc("st.d0",  1'b1, 11'h123, 1'b0);
    ch.d = $urandom; route = 10'($urandom);
    cyc("st.d1",  1'b1, 11'h115, 1'b0);
    ch.d = $urandom; route = 10'($urandom);
    cyc("st.d2",  1'b1, 11'h678, 1'b1);
    chk("st.code_err_sticky", {31'd0, code_err}, 32'd1);
    ch.d = 32'h0;
    cyc("st.end", 1'b0, 11'h000, 1'b1);

    // ---- Asynchronous reset mid-packet (in D0)
    ch.d = 32'h2ABC_DEF5; route = 10'h155; ch.v = 1'b1;
    cyc("rs.idle", 1'b0, 11'h000, 1'b1);
    ch.v = 1'b0;
    cyc("rs.hdr", 1'b1, 11'h155, 1'b0);
    #1;
    chk("rs.d0.wrreq", {31'd0, wrreq}, 32'd1);
    chk("rs.d0.busy",  {31'd0, busy},  32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rs.wrreq",    {31'd0, wrreq},    32'd0);
    chk("rs.busy",     {31'd0, busy},     32'd0);
    chk("rs.a",        {31'd0, ch.a},     32'd1);
    chk("rs.data",     {21'd0, data_out}, 32'd0);
    chk("rs.code_err", {31'd0, code_err}, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    ch.d = 32'h2ABC_DEF5; route = 10'h0F0; ch.v = 1'b1;
    cyc("rp.idle", 1'b0, 11'h000, 1'b1);
    ch.v = 1'b0;
    n_wr = 0;
    cyc("rp.hdr", 1'b1, 11'h0F0, 1'b0);
    cyc("rp.d0",  1'b1, 11'h2AB, 1'b0);
    cyc("rp.d1",  1'b1, 11'h337, 1'b0);
    cyc("rp.d2",  1'b1, 11'h6F5, 1'b1);
    cyc("rp.end", 1'b0, 11'h000, 1'b1);
    chk("rp.nwr", n_wr, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bz_serializer.md
Name: bz_serializer

Overview:
- Converts 32-bit core output words on a Channel into 11-bit router flit packets and writes them into the FIFO that feeds the router.
- Each packet is one header flit followed by three data flits.
- Transmit-side counterpart of the router-to-core deserializer; uses the same flit format: {tail, payload[9:0]}.
- Core word bits [31:30] are code bits that are always zero and are not routed.

Parameters:
- NPCin, 32: core word width. Only 32 is supported.
- NPCroute, 10: route field width. Equals the flit payload width; only 10 is supported.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- PC_in_channel  Channel  d[31:0], v, a  core word source. Serializer drives a; v and d are inputs.
- route  input  10  route for the packet; sampled together with d at word accept
- data_out  output  11  flit to FIFO: [10] tail, [9:0] payload
- wrreq  output  1  FIFO write request; one flit is written per cycle with wrreq=1
- isfull  input  1  FIFO full flag
- code_err  output  1  sticky flag: an accepted word had d[31:30] != 0
- busy  output  1  high whenever state != IDLE

Behaviour:
- Channel handshake: a word transfers on a rising clk edge with v=1 and a=1.
  - d and route are captured into internal registers word_r[29:0] and route_r[9:0].
  - d[31:30] are discarded, apart from setting code_err.
- States: IDLE, HDR, D0, D1, D2 (one-hot or binary, implementer's choice).
- IDLE:
  - a=1, wrreq=0, data_out=0.
  - On transfer, go to HDR; otherwise stay in IDLE.
- HDR:
  - data_out={1'b0, route_r}, wrreq=!isfull, a=0.
  - Go to D0 when !isfull; otherwise hold.
- D0:
  - data_out={1'b0, word_r[29:20]}, wrreq=!isfull, a=0.
  - Go to D1 when !isfull.
- D1:
  - data_out={1'b0, word_r[19:10]}, wrreq=!isfull, a=0.
  - Go to D2 when !isfull.
- D2:
  - data_out={1'b1, word_r[9:0]} (tail set), wrreq=!isfull, a=!isfull.
  - If !isfull and v: capture the new word and go to HDR (back-to-back).
  - If !isfull and !v: go to IDLE.
  - If isfull: hold, with a=0.
- Timing:
  - wrreq, a and data_out are combinational from state, isfull and the registers. The FIFO samples data_out on the same edge as wrreq.
  - Latency from transfer to header write: 1 cycle, with isfull=0.
  - Sustained throughput: 1 word per 4 cycles.
- Stall rules:
  - data_out holds its value while isfull=1 in any flit state.
  - No flit is skipped or duplicated.
  - wrreq is never asserted while isfull=1.
- Registers:
  - word_r and route_r change only on transfer. They are stable throughout a packet even if d or route toggle.
  - code_err is set on a transfer with d[31:30] != 0 and is cleared only by reset.
- Reset (asynchronous, any time):
  - state=IDLE, word_r=0, route_r=0, code_err=0.
  - Outputs immediately become a=1, wrreq=0, data_out=0, busy=0.
  - Reset mid-packet abandons the packet. Flits already written stay in the FIFO; the FIFO and downstream router are reset on the same reset.
- Simultaneous events: isfull rising in D2 while v=1 means no write and no accept that cycle. Retry occurs on the next cycle with isfull=0.

Test Plan:
- Single word: d=0x2ABCDEF5, route=0x155, isfull=0.
  - Expect 4 consecutive writes: 0x155, 0x2AB, 0x337, 0x6F5.
  - Then IDLE, with a=1 on the cycle after the last write.
  - code_err=0.
- Backpressure: same word, isfull=1 for 3 cycles while in D1.
  - wrreq=0 for those cycles and data_out holds 0x337.
  - Then 0x337 and 0x6F5 are written once each; 4 writes total.
- Back-to-back: two words 0x00000001/route 0x001 and 0x3FFFFFFF/route 0x3FF, v held high.
  - Flits 0x001, 0x000, 0x000, 0x401, 0x3FF, 0x3FF, 0x3FF, 0x7FF on 8 consecutive cycles.
  - a=1 in the first word's D2 cycle.
- Code error: d=0xC0000000, route=0x000.
  - Flits 0x000, 0x000, 0x000, 0x400.
  - code_err=1 and stays 1 through later clean words until reset.
- Reset in D0 (asynchronous pulse between edges):
  - Immediately wrreq=0, busy=0, a=1, code_err=0.
  - The next word yields a complete, correct 4-flit packet.
- Input stability: change d and route every cycle during a packet.
  - Emitted flits match only the values captured at transfer.
